fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Instruction-fetch and PC-sequencing stage of the MIPS-31 core.
- Sits directly upstream of the instruction decoder. It fetches a word from instruction memory and presents it as `code` to the decoder.
- It then consumes the decoder's one-hot `instruct` vector, plus the register and ALU results, to compute the next PC.
- A small FSM supports instruction memories with variable latency.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset and fetched first.
- PC_W, 32, PC and address width. Fixed at 32 for this core.

Ports:
- clk  in  1  system clock; the only clock in the block.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address; always word-aligned.
- imem_rdata  in  32  instruction word from memory.
- imem_valid  in  1  imem_rdata is valid this cycle.
- code  out  32  registered instruction word, driven to the decoder.
- code_valid  out  1  `code` holds a live instruction.
- instruct  in  32  one-hot decode of `code`, returned from the decoder.
- rs_data  in  32  GPR[rs]; used as the jr target.
- alu_zero  in  1  rs==rt comparison result; used by beq/bne.
- ex_done  in  1  execute/writeback of the current instruction completes this cycle.
- pc  out  32  address of the instruction in `code`.
- link_addr  out  32  pc+4; jal writes this to $31.
- illegal  out  1  one-cycle pulse when instruct is zero or more than one bit is set.
- addr_err  out  1  one-cycle pulse when the jr target has bits [1:0] != 0.

Behaviour:
- Reset (asynchronous assertion; release synchronous to clk):
  - pc=RESET_PC, code=0, code_valid=0, imem_req=0, illegal=0, addr_err=0, state=IDLE.
  - link_addr is combinational pc+4, so it reads RESET_PC+4 during reset.
- FSM states are IDLE, FETCH and EXEC.
- IDLE:
  - Lasts exactly one cycle after reset release, then moves to FETCH.
  - imem_req=0.
- FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_valid.
  - On imem_valid: code<=imem_rdata, code_valid<=1, go to EXEC.
  - Minimum latency from request to code_valid is one cycle, when imem_valid is high in the first FETCH cycle.
- EXEC:
  - imem_req=0; code and pc are held stable.
  - Wait for ex_done. On ex_done: pc<=next_pc, code_valid<=0, go to FETCH.
  - imem_valid arriving in EXEC is ignored.
- next_pc priority (bit positions within instruct):
  - jr, bit16: rs_data with bits [1:0] forced to 0. addr_err pulses if rs_data[1:0]!=0.
  - j, bit29, or jal, bit30: {pc_plus4[31:28], code[25:0], 2'b00}.
  - beq, bit24, with alu_zero=1, or bne, bit25, with alu_zero=0: pc_plus4 + (sign_extend(code[15:0]) << 2). Arithmetic is 32-bit and wraps modulo 2^32.
  - Otherwise: pc_plus4 = pc+4, which wraps from 32'hFFFF_FFFC to 0.
- illegal:
  - Pulses on the ex_done cycle when instruct==0 or instruct has more than one bit set.
  - The PC still advances, with priority as above (pc_plus4 when instruct==0). There is no trap.
- addr_err and illegal are registered and high for exactly one cycle.
- Reset mid-operation, in any state including a pending imem_valid, aborts immediately; the FSM restarts from IDLE. Reset takes precedence over a simultaneous ex_done.
- ex_done asserted outside EXEC is ignored.
- The decoder path is combinational: instruct is valid in the same cycle as code.

Decomposition:
- Shared package `mips_pkg`:
  - Bit-index constants for the one-hot instruct vector (IDX_JR=16, IDX_BEQ=24, IDX_BNE=25, IDX_J=29, IDX_JAL=30, plus the remaining decode bits).
  - RESET_PC default.
  - Fetch state enum.
- Sub-module `next_pc_calc`: purely combinational next-PC mux, branch adder and illegal/addr_err detection. The parent holds the FSM and all registers.

Test Plan:
- Reset with imem_valid tied high, three sequential addu instructions (each instruct=32'h2), ex_done one cycle after code_valid -> imem_addr sequence 0x00400000, 0x00400004, 0x00400008; pc matches; link_addr=pc+4.
- beq at pc=0x00400010, imm=16'hFFFC, alu_zero=1 -> next fetch at 0x00400004. Same case with alu_zero=0 -> 0x00400014. bne with alu_zero=0, imm=0x0003 -> 0x00400020.
- j at pc=0x00400000 with code[25:0]=26'h0100040 -> next fetch at 0x00400100. jal -> same target, and link_addr=0x00400004 during EXEC.
- jr with rs_data=0x00400033 -> next fetch at 0x00400030, addr_err high for exactly 1 cycle. instruct=0 -> illegal pulse, next fetch at pc+4.
- imem_valid delayed 3 cycles -> imem_addr held and imem_req high for 4 cycles, code_valid rises the cycle after imem_valid. Spurious imem_valid and ex_done while in EXEC/FETCH respectively -> no state change.
- rst_n asserted mid-FETCH and, separately, together with ex_done -> outputs at reset values immediately; the first fetch after release is at 0x00400000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-31 front end: decode bit positions,
// the default reset PC and the fetch FSM encoding.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

    // Bit positions within the one-hot instruct vector from the decoder.
    localparam int IDX_SLL   = 0;
    localparam int IDX_ADDU  = 1;
    localparam int IDX_SUBU  = 2;
    localparam int IDX_AND   = 3;
    localparam int IDX_OR    = 4;
    localparam int IDX_XOR   = 5;
    localparam int IDX_NOR   = 6;
    localparam int IDX_SLT   = 7;
    localparam int IDX_SLTU  = 8;
    localparam int IDX_SRL   = 9;
    localparam int IDX_SRA   = 10;
    localparam int IDX_SLLV  = 11;
    localparam int IDX_SRLV  = 12;
    localparam int IDX_SRAV  = 13;
    localparam int IDX_JR    = 16;
    localparam int IDX_ADDIU = 17;
    localparam int IDX_ANDI  = 18;
    localparam int IDX_ORI   = 19;
    localparam int IDX_XORI  = 20;
    localparam int IDX_LUI   = 21;
    localparam int IDX_LW    = 22;
    localparam int IDX_SW    = 23;
    localparam int IDX_BEQ   = 24;
    localparam int IDX_BNE   = 25;
    localparam int IDX_SLTI  = 26;
    localparam int IDX_J     = 29;
    localparam int IDX_JAL   = 30;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t ST_IDLE  = 2'd0;
    localparam fetch_state_t ST_FETCH = 2'd1;
    localparam fetch_state_t ST_EXEC  = 2'd2;

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jr > j/jal > taken branch > pc+4,
// plus decode-error and misaligned-jr detection.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] code_low,
    input  logic [31:0] instruct,
    input  logic [31:0] rs_data,
    input  logic        alu_zero,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4,
    output logic        illegal_det,
    output logic        addr_err_det
);

    logic [31:0] br_off;
    logic        br_taken;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{code_low[15]}}, code_low[15:0], 2'b00};
    assign br_taken = (instruct[IDX_BEQ] && alu_zero) || (instruct[IDX_BNE] && !alu_zero);

    always_comb begin
        next_pc = pc_plus4;
        if (instruct[IDX_JR]) begin
            next_pc = {rs_data[31:2], 2'b00};
        end else if (instruct[IDX_J] || instruct[IDX_JAL]) begin
            next_pc = {pc_plus4[31:28], code_low, 2'b00};
        end else if (br_taken) begin
            next_pc = pc_plus4 + br_off;
        end
    end

    assign illegal_det  = !is_onehot(instruct);
    assign addr_err_det = instruct[IDX_JR] && (rs_data[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch / PC sequencing stage: IDLE -> FETCH (wait imem_valid) -> EXEC
// (wait ex_done) -> FETCH, holding code and pc stable during EXEC.
module fetch_pc_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          PC_W     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [31:0]     code,
    output logic            code_valid,
    input  logic [31:0]     instruct,
    input  logic [31:0]     rs_data,
    input  logic            alu_zero,
    input  logic            ex_done,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] link_addr,
    output logic            illegal,
    output logic            addr_err
);

    fetch_state_t state;
    logic [31:0]  next_pc;
    logic [31:0]  pc_plus4;
    logic         illegal_det;
    logic         addr_err_det;

    next_pc_calc u_next_pc (
        .pc           (pc),
        .code_low     (code[25:0]),
        .instruct     (instruct),
        .rs_data      (rs_data),
        .alu_zero     (alu_zero),
        .next_pc      (next_pc),
        .pc_plus4     (pc_plus4),
        .illegal_det  (illegal_det),
        .addr_err_det (addr_err_det)
    );

    assign imem_req  = (state == ST_FETCH);
    assign imem_addr = pc;
    assign link_addr = pc_plus4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            code       <= 32'd0;
            code_valid <= 1'b0;
            illegal    <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            // Error flags are single-cycle pulses; default them low.
            illegal  <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                ST_IDLE: state <= ST_FETCH;
                ST_FETCH: begin
                    if (imem_valid) begin
                        code       <= imem_rdata;
                        code_valid <= 1'b1;
                        state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (ex_done) begin
                        pc         <= next_pc;
                        code_valid <= 1'b0;
                        illegal    <= illegal_det;
                        addr_err   <= addr_err_det;
                        state      <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a chained vector table plus reset
// corner sequences, each vector checked against hand-computed values.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_valid = 1'b0;
    logic [31:0] code;
    logic        code_valid;
    logic [31:0] instruct = 32'd0;
    logic [31:0] rs_data = 32'd0;
    logic        alu_zero = 1'b0;
    logic        ex_done = 1'b0;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        illegal;
    logic        addr_err;

    int n_vec  = 0;
    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] I_ADDU = 32'h0000_0002;
    localparam logic [31:0] I_JR   = 32'h0001_0000;
    localparam logic [31:0] I_BEQ  = 32'h0100_0000;
    localparam logic [31:0] I_BNE  = 32'h0200_0000;
    localparam logic [31:0] I_J    = 32'h2000_0000;
    localparam logic [31:0] I_JAL  = 32'h4000_0000;

    fetch_pc_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .code       (code),
        .code_valid (code_valid),
        .instruct   (instruct),
        .rs_data    (rs_data),
        .alu_zero   (alu_zero),
        .ex_done    (ex_done),
        .pc         (pc),
        .link_addr  (link_addr),
        .illegal    (illegal),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] code;
        logic [31:0] instr;
        logic [31:0] rs;
        logic        az;
        int          dly;
        logic        ill;
        logic        aerr;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_pc", pc, 32'h0040_0000);
        check("rst_code", code, 32'd0);
        check("rst_code_valid", {31'd0, code_valid}, 32'd0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_illegal", {31'd0, illegal}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_link_addr", link_addr, 32'h0040_0004);
    endtask

    // Wait for a fetch, hold imem_valid off for dly cycles (spurious ex_done
    // meanwhile), then return the word and check the captured instruction.
    task automatic fetch_phase(input logic [31:0] exp_addr, input logic [31:0] word, input int dly);
        int t = 0;
        while (!imem_req && t < 8) begin
            @(negedge clk);
            t++;
        end
        check("fetch_req_seen", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i <= dly; i++) begin
            check("fetch_req", {31'd0, imem_req}, 32'd1);
            check("fetch_addr", imem_addr, exp_addr);
            check("fetch_code_valid_low", {31'd0, code_valid}, 32'd0);
            imem_valid = (i == dly);
            imem_rdata = (i == dly) ? word : 32'hDEAD_BEEF;
            ex_done    = (i < dly);
            instruct   = I_J;
            @(negedge clk);
        end
        imem_valid = 1'b0;
        ex_done    = 1'b0;
        check("cap_code_valid", {31'd0, code_valid}, 32'd1);
        check("cap_code", code, word);
        check("cap_pc", pc, exp_addr);
        check("cap_link_addr", link_addr, exp_addr + 32'd4);
        check("cap_imem_req_low", {31'd0, imem_req}, 32'd0);
        check("cap_pulses_cleared", {30'd0, illegal, addr_err}, 32'd0);
    endtask

    task automatic exec_phase(input vec_t v);
        instruct   = v.instr;
        rs_data    = v.rs;
        alu_zero   = v.az;
        imem_valid = 1'b1;
        imem_rdata = ~v.code;
        @(negedge clk);
        imem_valid = 1'b0;
        check("exec_hold_code", code, v.code);
        check("exec_hold_pc", pc, v.pc);
        check("exec_hold_valid", {31'd0, code_valid}, 32'd1);
        ex_done = 1'b1;
        @(negedge clk);
        ex_done = 1'b0;
        check("exec_illegal", {31'd0, illegal}, {31'd0, v.ill});
        check("exec_addr_err", {31'd0, addr_err}, {31'd0, v.aerr});
        check("exec_code_valid_low", {31'd0, code_valid}, 32'd0);
        n_vec++;
    endtask

    initial begin
        //            pc            code          instr           rs            az dly ill aerr
        vecs[0]  = '{32'h0040_0000, 32'h0085_1021, I_ADDU,         32'd0,        0, 0, 0, 0};
        vecs[1]  = '{32'h0040_0004, 32'h0085_1021, I_ADDU,         32'd0,        0, 3, 0, 0};
        vecs[2]  = '{32'h0040_0008, 32'h0085_1021, I_ADDU,         32'd0,        0, 1, 0, 0};
        vecs[3]  = '{32'h0040_000C, 32'h0085_1021, I_ADDU,         32'd0,        0, 0, 0, 0};
        vecs[4]  = '{32'h0040_0010, 32'h1085_FFFC, I_BEQ,          32'd0,        1, 0, 0, 0};
        vecs[5]  = '{32'h0040_0004, 32'h0085_1021, I_ADDU,         32'd0,        0, 2, 0, 0};
        vecs[6]  = '{32'h0040_0008, 32'h0085_1021, I_ADDU,         32'd0,        0, 0, 0, 0};
        vecs[7]  = '{32'h0040_000C, 32'h0085_1021, I_ADDU,         32'd0,        0, 0, 0, 0};
        vecs[8]  = '{32'h0040_0010, 32'h1085_FFFC, I_BEQ,          32'd0,        0, 0, 0, 0};
        vecs[9]  = '{32'h0040_0014, 32'h0810_0004, I_J,            32'd0,        0, 1, 0, 0};
        vecs[10] = '{32'h0040_0010, 32'h1485_0003, I_BNE,          32'd0,        0, 0, 0, 0};
        vecs[11] = '{32'h0040_0020, 32'h0080_0008, I_JR,           32'h0040_0033, 0, 0, 0, 1};
        vecs[12] = '{32'h0040_0030, 32'h0000_0000, 32'd0,          32'd0,        0, 0, 1, 0};
        vecs[13] = '{32'h0040_0034, 32'h0810_0040, I_J,            32'd0,        0, 0, 0, 0};
        vecs[14] = '{32'h0040_0100, 32'h0810_0040, I_J | I_ADDU,   32'd0,        0, 0, 1, 0};
        vecs[15] = '{32'h0040_0100, 32'h1485_0003, I_BNE,          32'd0,        1, 0, 0, 0};
        vecs[16] = '{32'h0040_0104, 32'h1085_0010, I_BEQ,          32'd0,        1, 2, 0, 0};
        vecs[17] = '{32'h0040_0148, 32'h0080_0008, I_JR,           32'h0040_0200, 0, 0, 0, 0};
        vecs[18] = '{32'h0040_0200, 32'h0080_0008, I_JR,           32'hFFFF_FFFC, 0, 0, 0, 0};
        vecs[19] = '{32'hFFFF_FFFC, 32'h0085_1021, I_ADDU,         32'd0,        0, 0, 0, 0};
        vecs[20] = '{32'h0000_0000, 32'h0810_0040, I_J,            32'd0,        0, 0, 0, 0};

        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        check("idle_no_req", {31'd0, imem_req}, 32'd0);

        for (int i = 0; i < 21; i++) begin
            fetch_phase(vecs[i].pc, vecs[i].code, vecs[i].dly);
            exec_phase(vecs[i]);
        end

        // Reset mid-FETCH with imem_valid pending in the same cycle.
        check("post_table_addr", imem_addr, 32'h0040_0100);
        @(negedge clk);
        check("wait_addr_held", imem_addr, 32'h0040_0100);
        imem_valid = 1'b1;
        imem_rdata = 32'h1234_5678;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        imem_valid = 1'b0;
        check_reset_values();
        rst_n = 1'b1;
        check("idle_no_req_2", {31'd0, imem_req}, 32'd0);

        fetch_phase(32'h0040_0000, 32'h0810_0040, 0);
        exec_phase('{32'h0040_0000, 32'h0810_0040, I_J, 32'd0, 0, 0, 0, 0});

        // Reset together with ex_done: reset must win, no PC update or pulse.
        fetch_phase(32'h0040_0100, 32'h0080_0008, 1);
        instruct = I_JR;
        rs_data  = 32'h0000_0503;
        ex_done  = 1'b1;
        rst_n    = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        ex_done = 1'b0;
        check_reset_values();
        rst_n = 1'b1;

        fetch_phase(32'h0040_0000, 32'h0C10_0040, 0);
        check("jal_link_addr", link_addr, 32'h0040_0004);
        exec_phase('{32'h0040_0000, 32'h0C10_0040, I_JAL, 32'd0, 0, 0, 0, 0});
        fetch_phase(32'h0040_0100, 32'h0085_1021, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
